// File: rtl/ib_sched_pkg.sv
// Shared types and helpers for the matrix-unit input buffer scheduler.
package ib_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // The last buffer row starts queue_num-1 cycles late, so the skewed drain
  // window is one row length plus that skew.
  function automatic int unsigned drain_cycles(input int unsigned queue_num,
                                               input int unsigned queue_len);
    return queue_len + queue_num - 1;
  endfunction

endpackage

// File: rtl/input_buffer_sched.sv
// Per-tile sequencer for the matrix-unit input buffer: load gate, fill wait,
// data-out issue and skewed drain window timing for a job of N tiles.
//
// state | meaning
// IDLE  | waiting for a job start
// LOAD  | gating one source->buffer load (needs src valid and buffer prepared)
// FILL  | waiting for buffer full and PE array ready
// ISSUE | one-cycle ctrl_data_out to the buffer
// DRAIN | pe_valid window, DRAIN_CYC cycles, then next tile or finish
// DONE  | one-cycle job completion pulse
module input_buffer_sched
  import ib_sched_pkg::*;
#(
  parameter int unsigned QUEUE_NUM = 3,
  parameter int unsigned QUEUE_LEN = 9,
  parameter int unsigned TILE_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [TILE_W-1:0] i_tile_num,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_src_valid,
  output logic              o_src_ready,
  output logic              o_ib_pre_valid,
  input  logic              i_ib_pre_ready,
  input  logic              i_ib_data_in_done,
  output logic              o_ib_ctrl_data_out,
  input  logic              i_pe_ready,
  output logic              o_pe_valid,
  output logic [TILE_W-1:0] o_tile_idx
);

  localparam int unsigned DRAIN_CYC = drain_cycles(QUEUE_NUM, QUEUE_LEN);
  localparam int unsigned CNT_W     = $clog2(DRAIN_CYC + 1);

  state_t            state;
  logic [TILE_W-1:0] tile_num;
  logic [TILE_W-1:0] tile_idx;
  logic [CNT_W-1:0]  drain_cnt;
  logic              fire;

  // The load gate is the only path combinational from inputs: the buffer may
  // still be flushing when LOAD is entered, so pre_ready must qualify it live.
  assign fire = (state == LOAD) && i_src_valid && i_ib_pre_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      tile_num  <= '0;
      tile_idx  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            tile_num <= i_tile_num;
            tile_idx <= '0;
            state    <= (i_tile_num == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (fire) state <= FILL;
        end
        FILL: begin
          if (i_ib_data_in_done && i_pe_ready) state <= ISSUE;
        end
        ISSUE: begin
          drain_cnt <= CNT_W'(DRAIN_CYC);
          state     <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CNT_W'(1);
          if (drain_cnt == CNT_W'(1)) begin
            if (tile_idx == tile_num - TILE_W'(1)) begin
              state <= DONE;
            end else begin
              tile_idx <= tile_idx + TILE_W'(1);
              state    <= LOAD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy             = (state != IDLE) && (state != DONE);
  assign o_done             = (state == DONE);
  assign o_src_ready        = fire;
  assign o_ib_pre_valid     = fire;
  assign o_ib_ctrl_data_out = (state == ISSUE);
  assign o_pe_valid         = (state == DRAIN);
  assign o_tile_idx         = tile_idx;

endmodule
